// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares the single unified memory between the CPU datapath port
// and the loader/debug port. The CPU has fixed priority, but a loader that has
// lost MAX_WAIT consecutive arbitrations is forced through. Only one
// transaction is in flight at a time: IDLE -> ISSUE -> (WAIT)* -> DONE -> IDLE.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MEM_LAT  = 1,  // 1..4: read data valid MEM_LAT cycles after mem_en
  parameter int MAX_WAIT = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  // CPU datapath port
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  // loader/debug port
  input  logic          ldr_req_i,
  input  logic          ldr_we_i,
  input  logic [AW-1:0] ldr_addr_i,
  input  logic [DW-1:0] ldr_wdata_i,
  output logic [DW-1:0] ldr_rdata_o,
  output logic          ldr_ack_o,
  // memory side
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          busy_o
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam int LCW = 3;  // enough to count up to MEM_LAT-1 for MEM_LAT <= 4

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [LCW-1:0] lat_cnt_q, lat_cnt_d;
  logic           owner_ldr_q, owner_ldr_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]  ldr_rdata_q, ldr_rdata_d;
  logic           grant;
  logic           grant_ldr;
  logic           capture;

  // Next-state logic: arbitration, transaction sequencing and read capture.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    owner_ldr_d = owner_ldr_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    grant       = 1'b0;
    grant_ldr   = 1'b0;
    capture     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req_i || ldr_req_i) begin
          grant     = 1'b1;
          // CPU wins ties unless the loader has been starved MAX_WAIT times.
          grant_ldr = ldr_req_i && (!cpu_req_i || wait_cnt_q == WCW'(MAX_WAIT));
          owner_ldr_d = grant_ldr;
          we_d        = grant_ldr ? ldr_we_i    : cpu_we_i;
          addr_d      = grant_ldr ? ldr_addr_i  : cpu_addr_i;
          wdata_d     = grant_ldr ? ldr_wdata_i : cpu_wdata_i;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          lat_cnt_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // A read spends MEM_LAT cycles here; the last one is the cycle in
        // which the memory presents the data, so it is captured at its end
        // and is already on the owner's rdata output when the ack pulses.
        if (lat_cnt_q == LCW'(MEM_LAT - 1)) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + LCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      if (owner_ldr_q) ldr_rdata_d = mem_rdata_i;
      else             cpu_rdata_d = mem_rdata_i;
    end

    // Starvation counter: only meaningful while the loader keeps asking.
    if (!ldr_req_i || (grant && grant_ldr)) begin
      wait_cnt_d = '0;
    end else if (grant && wait_cnt_q != WCW'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: the latched request and read-data registers are reset too, because
    // the memory-side and rdata outputs must read zero while reset is held.
    if (reset_i) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      owner_ldr_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      owner_ldr_q <= owner_ldr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Outputs decode from state and latched registers only, never from *_req.
  assign mem_en_o    = (state_q == ISSUE);
  assign mem_we_o    = mem_en_o && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_ack_o   = (state_q == DONE) && !owner_ldr_q;
  assign ldr_ack_o   = (state_q == DONE) &&  owner_ldr_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign ldr_rdata_o = ldr_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share one
// set of request inputs; each has its own memory model and a transaction-level
// reference model that predicts every output on every cycle.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

  logic [31:0] cpu_rdata [2];
  logic [31:0] ldr_rdata [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        cpu_ack   [2];
  logic        ldr_ack   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic        busy      [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_WAIT(MAX_WAIT)) u_lat1 (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata[0]), .cpu_ack_o(cpu_ack[0]),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_rdata_o(ldr_rdata[0]), .ldr_ack_o(ldr_ack[0]),
    .mem_en_o(mem_en[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_WAIT(MAX_WAIT)) u_lat3 (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata[1]), .cpu_ack_o(cpu_ack[1]),
    .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_rdata_o(ldr_rdata[1]), .ldr_ack_o(ldr_ack[1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  // Memory contents: env_mem is what each instance's memory really holds,
  // ref_mem is the reference model's view, updated only by predicted writes.
  logic [31:0] env_mem [2][64];
  logic [31:0] ref_mem [2][64];

  // Environment: one outstanding read per instance, answered after MEM_LAT.
  bit          rd_pend [2];
  int          rd_cyc  [2];
  logic [31:0] rd_addr [2];

  // Reference model: a transaction started in idle cycle m_start completes
  // 2 cycles later (write) or MEM_LAT+2 cycles later (read).
  bit          m_busy  [2];
  int          m_start [2];
  bit          m_owner [2];  // 1 = loader
  bit          m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rd    [2][2];
  int          m_wcnt  [2];

  task automatic model_step(input int i);
    int d, end_d;
    bit e_en, e_we, e_cack, e_lack, to_ldr, granted;
    if (reset) begin
      m_busy[i] = 0; m_wcnt[i] = 0; m_owner[i] = 0; m_we[i] = 0;
      m_addr[i] = '0; m_wdata[i] = '0; m_rd[i][0] = '0; m_rd[i][1] = '0;
    end
    d      = cyc - m_start[i];
    end_d  = m_we[i] ? 2 : lat_of(i) + 2;
    e_en   = m_busy[i] && d == 1;
    e_we   = e_en && m_we[i];
    e_cack = m_busy[i] && d == end_d && !m_owner[i];
    e_lack = m_busy[i] && d == end_d &&  m_owner[i];
    if (e_we) ref_mem[i][widx(m_addr[i])] = m_wdata[i];
    if (m_busy[i] && d == end_d && !m_we[i]) m_rd[i][m_owner[i]] = ref_mem[i][widx(m_addr[i])];

    check($sformatf("i%0d c%0d busy", i, cyc),      busy[i],      m_busy[i]);
    check($sformatf("i%0d c%0d mem_en", i, cyc),    mem_en[i],    e_en);
    check($sformatf("i%0d c%0d mem_we", i, cyc),    mem_we[i],    e_we);
    check($sformatf("i%0d c%0d mem_addr", i, cyc),  mem_addr[i],  m_addr[i]);
    check($sformatf("i%0d c%0d mem_wdata", i, cyc), mem_wdata[i], m_wdata[i]);
    check($sformatf("i%0d c%0d cpu_ack", i, cyc),   cpu_ack[i],   e_cack);
    check($sformatf("i%0d c%0d ldr_ack", i, cyc),   ldr_ack[i],   e_lack);
    check($sformatf("i%0d c%0d cpu_rdata", i, cyc), cpu_rdata[i], m_rd[i][0]);
    check($sformatf("i%0d c%0d ldr_rdata", i, cyc), ldr_rdata[i], m_rd[i][1]);

    if (!reset) begin
      granted = 0;
      to_ldr  = 0;
      if (m_busy[i]) begin
        if (d == end_d) m_busy[i] = 0;
      end else if (cpu_req || ldr_req) begin
        granted    = 1;
        to_ldr     = ldr_req && (!cpu_req || m_wcnt[i] == MAX_WAIT);
        m_busy[i]  = 1;
        m_start[i] = cyc;
        m_owner[i] = to_ldr;
        m_we[i]    = to_ldr ? ldr_we    : cpu_we;
        m_addr[i]  = to_ldr ? ldr_addr  : cpu_addr;
        m_wdata[i] = to_ldr ? ldr_wdata : cpu_wdata;
      end
      if (!ldr_req || (granted && to_ldr)) m_wcnt[i] = 0;
      else if (granted && m_wcnt[i] < MAX_WAIT) m_wcnt[i]++;
    end
  endtask

  // Mid-cycle: serve the memories, then compare every output to the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rd_pend[i] = 0;
      end else if (mem_en[i]) begin
        if (mem_we[i]) begin
          env_mem[i][widx(mem_addr[i])] = mem_wdata[i];
        end else begin
          rd_pend[i] = 1;
          rd_cyc[i]  = cyc;
          rd_addr[i] = mem_addr[i];
        end
      end
      if (rd_pend[i] && cyc == rd_cyc[i] + lat_of(i)) begin
        mem_rdata[i] = env_mem[i][widx(rd_addr[i])];
        rd_pend[i]   = 0;
      end else begin
        mem_rdata[i] = $urandom;  // garbage outside the valid cycle
      end
      model_step(i);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    #1;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      tick();
      probe();
      if (!busy[0] && !busy[1]) done = 1;
    end
    check({tag, "_idle"}, done, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    bit got;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) begin
        env_mem[i][w] = 32'hC0DE_0000 + 32'(w * 17);
        ref_mem[i][w] = env_mem[i][w];
      end
      env_mem[i][4] = 32'hDEAD_BEEF;  // address 0x10
      ref_mem[i][4] = 32'hDEAD_BEEF;
    end

    // Reset state.
    repeat (3) tick();
    probe();
    check("rst_busy", busy[0], 1'b0);
    check("rst_mem_en", mem_en[1], 1'b0);
    check("rst_cpu_rdata", cpu_rdata[0], 32'h0);
    tick();
    reset = 1'b0;

    // CPU read of 0x10: latency 1 (u_lat1) and latency 3 (u_lat3).
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = $urandom;
    probe(); check("t1_c0_busy", busy[0], 1'b0);
    tick(); probe();
    check("t1_c1_mem_en", mem_en[0], 1'b1);
    check("t1_c1_mem_we", mem_we[0], 1'b0);
    check("t1_c1_addr", mem_addr[0], 32'h10);
    check("t4_c1_mem_en", mem_en[1], 1'b1);
    tick(); probe();
    check("t1_c2_mem_en", mem_en[0], 1'b0);
    check("t1_c2_ack", cpu_ack[0], 1'b0);
    check("t4_c2_busy", busy[1], 1'b1);
    tick(); cpu_req = 0; probe();
    check("t1_c3_ack", cpu_ack[0], 1'b1);
    check("t1_c3_rdata", cpu_rdata[0], 32'hDEAD_BEEF);
    check("t1_c3_ldr_rdata", ldr_rdata[0], 32'h0);
    check("t4_c3_ack", cpu_ack[1], 1'b0);
    tick(); probe();
    check("t4_c4_busy", busy[1], 1'b1);
    check("t4_c4_ack", cpu_ack[1], 1'b0);
    tick(); probe();
    check("t4_c5_ack", cpu_ack[1], 1'b1);
    check("t4_c5_rdata", cpu_rdata[1], 32'hDEAD_BEEF);
    check("t4_c5_busy", busy[1], 1'b1);
    tick(); probe();
    check("t4_c6_busy", busy[1], 1'b0);
    wait_idle("t1");

    // Loader write of 0x12345678 to 0x40.
    tick();
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h40; ldr_wdata = 32'h1234_5678;
    probe(); check("t2_c0_cpu_ack", cpu_ack[0], 1'b0);
    tick(); probe();
    check("t2_c1_mem_en", mem_en[0], 1'b1);
    check("t2_c1_mem_we", mem_we[0], 1'b1);
    check("t2_c1_addr", mem_addr[0], 32'h40);
    check("t2_c1_wdata", mem_wdata[0], 32'h1234_5678);
    tick(); ldr_req = 0; probe();
    check("t2_c2_mem_en", mem_en[0], 1'b0);
    check("t2_c2_ldr_ack", ldr_ack[0], 1'b1);
    check("t2_c2_cpu_ack", cpu_ack[0], 1'b0);
    tick(); probe();
    check("t2_c3_ldr_ack", ldr_ack[0], 1'b0);
    check("t2_c3_cpu_ack", cpu_ack[0], 1'b0);
    wait_idle("t2");

    // Both requesting continuously: 8 CPU wins, then the loader, then CPU.
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = $urandom;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h24; ldr_wdata = $urandom;
    for (int n = 0; n < 100 && q.size() < 10; n++) begin
      probe();
      if (cpu_ack[0]) q.push_back(0);
      if (ldr_ack[0]) q.push_back(1);
      tick();
    end
    cpu_req = 0; ldr_req = 0;
    check("t3_ack_count", q.size(), 10);
    for (int k = 0; k < q.size(); k++) check($sformatf("t3_ack%0d_owner", k), q[k], (k == 8));
    wait_idle("t3");

    // Reset during the WAIT of a read.
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    tick();
    tick();
    reset = 1; cpu_req = 0;
    probe();
    check("t5_busy", busy[1], 1'b0);
    check("t5_mem_en", mem_en[1], 1'b0);
    check("t5_cpu_ack", cpu_ack[1], 1'b0);
    check("t5_cpu_rdata", cpu_rdata[1], 32'h0);
    check("t5_busy0", busy[0], 1'b0);
    tick();
    reset = 0;
    for (int n = 0; n < 6; n++) begin
      probe();
      check($sformatf("t5_no_ack%0d", n), cpu_ack[1] | cpu_ack[0], 1'b0);
      tick();
    end
    ldr_req = 1; ldr_we = 0; ldr_addr = 32'h40;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick(); probe();
      if (ldr_ack[1]) begin
        got = 1;
        check("t5_new_rdata", ldr_rdata[1], 32'h1234_5678);
      end
    end
    check("t5_new_ack_seen", got, 1'b1);
    ldr_req = 0;
    wait_idle("t5");

    // Request dropped mid-transaction; loader arriving while busy.
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = $urandom;
    tick();
    cpu_req = 0;
    ldr_req = 1; ldr_we = 1; ldr_addr = 32'h34; ldr_wdata = $urandom;
    probe(); check("t6_c1_addr", mem_addr[0], 32'h30);
    tick(); probe();
    check("t6_c2_cpu_ack0", cpu_ack[0], 1'b1);
    check("t6_c2_cpu_ack1", cpu_ack[1], 1'b1);
    tick(); probe();
    check("t6_c3_busy", busy[0], 1'b0);
    tick(); probe();
    check("t6_c4_mem_en", mem_en[0], 1'b1);
    check("t6_c4_addr", mem_addr[0], 32'h34);
    tick(); ldr_req = 0; probe();
    check("t6_c5_ldr_ack", ldr_ack[0], 1'b1);
    wait_idle("t6");

    // Randomized traffic; the reference model checks every cycle.
    for (int n = 0; n < 2000; n++) begin
      tick();
      reset     = (n == 1000);
      cpu_req   = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) ldr_req = ~ldr_req;
      cpu_we    = 1'($urandom_range(0, 1));
      ldr_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 32'($urandom_range(0, 15)) << 2;
      ldr_addr  = 32'($urandom_range(0, 15)) << 2;
      cpu_wdata = $urandom;
      ldr_wdata = $urandom;
    end
    tick();
    reset = 0; cpu_req = 0; ldr_req = 0;
    wait_idle("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
